uart_cfg_frame_parser: RTL and testbench

Sequencing controller that sits directly behind the UART byte receiver in the threshold-setting path. It consumes received bytes (data + one-cycle done strobe), assembles 4-byte command frames, validates header, address and checksum, and commits the payload into a bank of 8-bit configuration/threshold registers that feed the tracker's colour-threshold logic. A frame that stalls mid-way is dropped by an inter-byte timeout. Every completed or rejected frame produces a one-cycle status pulse.

---
 rtl/uart_cfg_frame_parser.sv | 129 ++++++++++++
 tb/tb_uart_cfg_frame_parser.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_frame_parser.sv
// Assembles 4-byte HEADER/ADDR/DATA/CHK frames from the UART receiver and commits
// validated payloads into a bank of 8-bit configuration registers.
module uart_cfg_frame_parser #(
  parameter int unsigned NUM_REGS       = 8,
  parameter logic [7:0]  RESET_VAL      = 8'h80,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 500000
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rx_done,
  output logic [8*NUM_REGS-1:0] cfg_bus,
  output logic                  cfg_we,
  output logic [3:0]            cfg_addr,
  output logic [7:0]            cfg_data,
  output logic                  frame_err,
  output logic [1:0]            err_code,
  output logic [7:0]            good_cnt,
  output logic [7:0]            err_cnt
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StGetAddr, StGetData, StGetChk} state_e;

  state_e          state_q;
  logic [CntW-1:0] tmo_cnt_q;
  logic [7:0]      addr_q, data_q;
  logic [7:0]      regs_q [NUM_REGS];
  logic            cfg_we_q, frame_err_q;
  logic [3:0]      cfg_addr_q;
  logic [7:0]      cfg_data_q;
  logic [1:0]      err_code_q;
  logic [7:0]      good_cnt_q, err_cnt_q;

  logic            tmo_hit;
  logic [7:0]      chk_sum;
  logic            addr_bad;

  // The counter is cleared on the strobe edge, so it reads TIMEOUT_CYCLES-2 on the
  // edge where it would reach the terminal count.
  assign tmo_hit  = (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 2));
  assign chk_sum  = addr_q + data_q;
  assign addr_bad = (32'(addr_q) >= NUM_REGS);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= StIdle;
      tmo_cnt_q   <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      cfg_we_q    <= 1'b0;
      frame_err_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
      err_code_q  <= 2'b00;
      good_cnt_q  <= '0;
      err_cnt_q   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      cfg_we_q    <= 1'b0;
      frame_err_q <= 1'b0;

      if (state_q == StIdle || rx_done) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end

      // A byte arriving on the terminal-count cycle takes priority over the timeout.
      if (state_q != StIdle && !rx_done && tmo_hit) begin
        state_q     <= StIdle;
        frame_err_q <= 1'b1;
        err_code_q  <= 2'b11;
        err_cnt_q   <= (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
      end else if (rx_done) begin
        unique case (state_q)
          StIdle: begin
            if (rx_data == HEADER) state_q <= StGetAddr;
          end
          StGetAddr: begin
            addr_q  <= rx_data;
            state_q <= StGetData;
          end
          StGetData: begin
            data_q  <= rx_data;
            state_q <= StGetChk;
          end
          StGetChk: begin
            state_q <= StIdle;
            if (addr_bad || chk_sum != rx_data) begin
              frame_err_q <= 1'b1;
              err_code_q  <= addr_bad ? 2'b10 : 2'b01;
              err_cnt_q   <= (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
            end else begin
              for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (addr_q == 8'(i)) regs_q[i] <= data_q;
              end
              cfg_we_q   <= 1'b1;
              cfg_addr_q <= addr_q[3:0];
              cfg_data_q <= data_q;
              good_cnt_q <= good_cnt_q + 8'd1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  always_comb begin
    cfg_bus = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      cfg_bus[8*i +: 8] = regs_q[i];
    end
  end

  assign cfg_we    = cfg_we_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;
  assign frame_err = frame_err_q;
  assign err_code  = err_code_q;
  assign good_cnt  = good_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cfg_frame_parser.sv
// Scoreboard bench: each frame's expected pulse is queued when its CHK byte is driven
// and compared when cfg_we or frame_err appears.
module tb_uart_cfg_frame_parser;

  localparam int unsigned NR = 8;
  localparam int unsigned TC = 100;
  localparam logic [7:0]  HDR = 8'hA5;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_done = 1'b0;
  logic [8*NR-1:0] cfg_bus;
  logic          cfg_we, frame_err;
  logic [3:0]    cfg_addr;
  logic [7:0]    cfg_data, good_cnt, err_cnt;
  logic [1:0]    err_code;

  uart_cfg_frame_parser #(
    .NUM_REGS      (NR),
    .RESET_VAL     (8'h80),
    .HEADER        (HDR),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .cfg_bus  (cfg_bus),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .frame_err(frame_err),
    .err_code (err_code),
    .good_cnt (good_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 Clk = ~Clk;

  int unsigned cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [1:0]  code;
    logic [7:0]  gcnt;
    logic [7:0]  ecnt;
    int unsigned at;
  } ev_t;

  ev_t         sb[$];
  logic [7:0]  m_regs[NR];
  logic [7:0]  m_good, m_err, m_data;
  logic [3:0]  m_addr;
  logic [1:0]  m_code;
  int unsigned last_strobe;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  always @(posedge Clk) begin
    ev_t e;
    #1;
    if (Rst_n && (cfg_we || frame_err)) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_pulse", {62'd0, cfg_we, frame_err}, 64'd0);
      end else begin
        e = sb.pop_front();
        check_eq("pulse_cycle", 64'(cyc), 64'(e.at));
        check_eq("pulse_kind", {62'd0, cfg_we, frame_err}, e.is_err ? 64'd1 : 64'd2);
        check_eq("held_addr", 64'(cfg_addr), 64'(e.addr));
        check_eq("held_data", 64'(cfg_data), 64'(e.data));
        check_eq("good_cnt", 64'(good_cnt), 64'(e.gcnt));
        check_eq("err_cnt", 64'(err_cnt), 64'(e.ecnt));
        if (e.is_err) check_eq("err_code", 64'(err_code), 64'(e.code));
        else          check_eq("reg_written", 64'(cfg_bus[8*e.addr +: 8]), 64'(e.data));
      end
    end
  end

  function automatic logic [63:0] model_bus();
    logic [63:0] v = '0;
    for (int i = 0; i < int'(NR); i++) v[8*i +: 8] = m_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(NR); i++) m_regs[i] = 8'h80;
    m_good = 0; m_err = 0; m_addr = 0; m_data = 0; m_code = 0;
  endtask

  task automatic push_ev(input bit is_err, input logic [1:0] code, input int unsigned at);
    ev_t e;
    if (is_err) begin
      m_code = code;
      if (m_err != 8'hFF) m_err++;
    end
    e.is_err = is_err; e.code = code; e.addr = m_addr; e.data = m_data;
    e.gcnt = m_good; e.ecnt = m_err; e.at = at;
    sb.push_back(e);
  endtask

  // Called just after a negedge; leaves the bench just after a negedge.
  task automatic drive_byte(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    last_strobe = cyc + 1;
    @(negedge Clk);
    rx_done = 1'b0;
    repeat (gap) @(negedge Clk);
  endtask

  task automatic expect_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    logic [7:0] s;
    s = a + d;
    if (a >= NR) push_ev(1'b1, 2'b10, cyc + 1);
    else if (s != c) push_ev(1'b1, 2'b01, cyc + 1);
    else begin
      m_regs[a[2:0]] = d; m_addr = a[3:0]; m_data = d; m_good++;
      push_ev(1'b0, 2'b00, cyc + 1);
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c,
                            input int gap);
    drive_byte(HDR, 1);
    drive_byte(a, 1);
    drive_byte(d, 1);
    expect_frame(a, d, c);
    drive_byte(c, gap);
  endtask

  task automatic do_reset();
    rx_done = 1'b0;
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
    @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] a, d, c;
    model_reset();
    @(negedge Clk);
    do_reset();

    check_eq("rst_bus", cfg_bus, 64'h8080808080808080);
    check_eq("rst_outs", {cfg_we, frame_err, cfg_addr, cfg_data, err_code, good_cnt, err_cnt},
             64'd0);

    send_frame(8'h03, 8'h5A, 8'h5D, 3);
    check_eq("f1_bus", cfg_bus, model_bus());
    check_eq("f1_good", 64'(good_cnt), 64'd1);
    send_frame(8'h02, 8'h10, 8'h13, 3);
    check_eq("f2_code", 64'(err_code), 64'd1);
    check_eq("f2_bus", cfg_bus, model_bus());
    send_frame(8'h09, 8'h00, 8'h09, 3);
    check_eq("f3_code", 64'(err_code), 64'd2);
    drive_byte(8'h11, 1);
    drive_byte(8'h22, 1);
    send_frame(8'h00, 8'hFF, 8'hFF, 3);
    check_eq("f4_bus", cfg_bus, model_bus());
    check_eq("f4_err", 64'(err_cnt), 64'd2);

    // Inter-byte timeout, then a clean frame to the same address.
    drive_byte(HDR, 1);
    drive_byte(8'h04, 0);
    push_ev(1'b1, 2'b11, last_strobe + TC - 1);
    repeat (TC + 10) @(negedge Clk);
    check_eq("tmo_code", 64'(err_code), 64'd3);
    send_frame(8'h04, 8'h01, 8'h05, 3);

    // Bytes landing exactly on and just before the terminal-count cycle.
    drive_byte(HDR, 1);
    drive_byte(8'h07, TC - 2);
    drive_byte(8'h33, TC - 3);
    expect_frame(8'h07, 8'h33, 8'h3A);
    drive_byte(8'h3A, 3);
    check_eq("tmo_edge_bus", cfg_bus, model_bus());

    // HEADER on the cycle right after the CHK strobe.
    send_frame(8'h01, 8'h02, 8'h03, 0);
    send_frame(8'h05, 8'h06, 8'h0B, 3);
    check_eq("b2b_bus", cfg_bus, model_bus());

    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom_range(0, 11));
      d = 8'($urandom);
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(a + d);
      send_frame(a, d, c, 2);
    end
    check_eq("rand_bus", cfg_bus, model_bus());
    check_eq("rand_good", 64'(good_cnt), 64'(m_good));

    // Reset mid-frame; the trailing CHK byte must be ignored.
    drive_byte(HDR, 1);
    drive_byte(8'h06, 1);
    drive_byte(8'h20, 1);
    do_reset();
    check_eq("mid_rst_bus", cfg_bus, 64'h8080808080808080);
    drive_byte(8'h26, 5);
    check_eq("post_rst_bus", cfg_bus, 64'h8080808080808080);
    check_eq("post_rst_cnt", {48'd0, good_cnt, err_cnt}, 64'd0);

    for (int i = 0; i < 256; i++) begin
      a = 8'(i % NR); d = 8'(i);
      send_frame(a, d, 8'(a + d), 1);
    end
    repeat (3) @(negedge Clk);
    check_eq("good_wrap", 64'(good_cnt), 64'd0);
    for (int i = 0; i < 300; i++) begin
      a = 8'(i % NR); d = 8'(i);
      send_frame(a, d, 8'(a + d + 1), 1);
    end
    repeat (3) @(negedge Clk);
    check_eq("err_sat", 64'(err_cnt), 64'd255);
    check_eq("final_bus", cfg_bus, model_bus());

    repeat (5) @(negedge Clk);
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
